// File: rtl/vermitypes_pkg.sv
// Shared types for the Vermi bus arbiter: bus-owner encoding (also used as the
// arbiter FSM state) and a helper that sizes the dbus run counter.
package vermitypes_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } arb_owner_t;

  // Width needed to hold a run count of 0..max_run inclusive.
  function automatic int run_width(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/vermi_arb_pick.sv
// Combinational owner selection for the Vermi bus arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed dbus priority
// with a D_MAX_RUN anti-starvation limit.
module vermi_arb_pick
  import vermitypes_pkg::*;
#(
  parameter int D_MAX_RUN = 4,
  parameter int D_RUN_W   = 3
) (
  input  logic               i_valid,
  input  logic               d_valid,
  input  arb_owner_t         last,
  input  logic [D_RUN_W-1:0] d_run,
  output arb_owner_t         owner
);

  arb_owner_t conflict_owner;

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_run;
  assign unused_run = ^d_run;

  // Alternate on conflict; `last` only ever holds I or D once out of reset.
  assign conflict_owner = (last == OWNER_I) ? OWNER_D : OWNER_I;
`else
  logic unused_last;
  assign unused_last = ^last;

  assign conflict_owner = (d_run >= D_RUN_W'(D_MAX_RUN)) ? OWNER_I : OWNER_D;
`endif

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    owner = OWNER_NONE;
    case ({i_valid, d_valid})
      2'b10:   owner = OWNER_I;
      2'b01:   owner = OWNER_D;
      2'b11:   owner = conflict_owner;
      default: owner = OWNER_NONE;
    endcase
  end

endmodule

// File: rtl/vermi_bus_arbiter.sv
// Shares one memory port between the core's instruction bus and data bus. The grant
// is locked from issue until m_ready. Build option: ARB_ROUND_ROBIN_EN (see vermi_arb_pick).
module vermi_bus_arbiter
  import vermitypes_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int D_MAX_RUN = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                i_valid,
  output logic                i_ready,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic [ADDR_W-1:0]   i_lookahead,
  output logic [DATA_W-1:0]   i_rdata,

  input  logic                d_valid,
  output logic                d_ready,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W/8-1:0] d_wstrobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_irq,

  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADDR_W-1:0]   m_address,
  output logic [ADDR_W-1:0]   m_lookahead,
  output logic [DATA_W/8-1:0] m_wstrobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_irq
);

  localparam int D_RUN_W = run_width(D_MAX_RUN);

  arb_owner_t         state_q, state_d;
  arb_owner_t         last_q, last_d;
  logic [D_RUN_W-1:0] d_run_q, d_run_d;
  arb_owner_t         pick_owner;
  arb_owner_t         owner;
  logic               i_done;
  logic               d_done;

  vermi_arb_pick #(
    .D_MAX_RUN (D_MAX_RUN),
    .D_RUN_W   (D_RUN_W)
  ) u_pick (
    .i_valid (i_valid),
    .d_valid (d_valid),
    .last    (last_q),
    .d_run   (d_run_q),
    .owner   (pick_owner)
  );

  // In IDLE the fresh pick drives the bus this cycle; in a LOCK state the holder keeps it.
  assign owner = (state_q == OWNER_NONE) ? pick_owner : state_q;

  always_comb begin
    m_valid     = 1'b0;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    m_address   = i_address;
    m_lookahead = i_lookahead;
    m_wstrobe   = '0;
    m_wdata     = '0;
    case (owner)
      OWNER_I: begin
        m_valid = !reset;
        i_ready = m_ready && !reset;
      end
      OWNER_D: begin
        m_valid     = !reset;
        d_ready     = m_ready && !reset;
        m_address   = d_address;
        m_lookahead = d_address;
        m_wstrobe   = d_wstrobe;
        m_wdata     = d_wdata;
      end
      default: ;
    endcase
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign d_irq   = m_irq;

  assign i_done = i_valid && i_ready;
  assign d_done = d_valid && d_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OWNER_NONE: if (owner != OWNER_NONE && !m_ready) state_d = owner;
      default:    if (m_ready) state_d = OWNER_NONE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (i_done)      last_d = OWNER_I;
    else if (d_done) last_d = OWNER_D;
  end

  // The run only counts dbus wins that actually made the ibus wait.
  always_comb begin
    d_run_d = d_run_q;
    if (i_done || !i_valid)
      d_run_d = '0;
    else if (d_done && d_run_q < D_RUN_W'(D_MAX_RUN))
      d_run_d = d_run_q + D_RUN_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OWNER_NONE;
      last_q  <= OWNER_D;
      d_run_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      d_run_q <= d_run_d;
    end
  end

endmodule

// File: tb/tb_vermi_bus_arbiter.sv
// Directed self-checking bench for vermi_bus_arbiter (default fixed-priority build;
// the round-robin scenario is selected when ARB_ROUND_ROBIN_EN is defined).
module tb_vermi_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        i_valid, i_ready;
  logic [31:0] i_address, i_lookahead, i_rdata;
  logic        d_valid, d_ready;
  logic [31:0] d_address, d_wdata, d_rdata;
  logic [3:0]  d_wstrobe;
  logic        d_irq;
  logic        m_valid, m_ready;
  logic [31:0] m_address, m_lookahead, m_wdata, m_rdata;
  logic [3:0]  m_wstrobe;
  logic        m_irq;

  int checks = 0;
  int errors = 0;

  vermi_bus_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .D_MAX_RUN (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_address   (i_address),
    .i_lookahead (i_lookahead),
    .i_rdata     (i_rdata),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_address   (d_address),
    .d_wstrobe   (d_wstrobe),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_irq       (d_irq),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_address   (m_address),
    .m_lookahead (m_lookahead),
    .m_wstrobe   (m_wstrobe),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .m_irq       (m_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, outputs are read 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_valid = 1'b1; d_valid = 1'b1; m_ready = 1'b1; m_irq = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got i=%b d=%b expected i=0 d=0", i_ready, d_ready);
    end
    checks++;
    if (d_irq !== 1'b1) begin errors++; $display("FAIL reset_irq_hi: got %b expected 1", d_irq); end
    m_irq = 1'b0;
    #1;
    checks++;
    if (d_irq !== 1'b0) begin errors++; $display("FAIL reset_irq_lo: got %b expected 0", d_irq); end
    step();
    step();
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_address !== i_address) begin
      errors++; $display("FAIL idle_bus: got valid=%b addr=%h expected valid=0 addr=%h", m_valid, m_address, i_address);
    end
  endtask

  task automatic test_single_ibus();
    step();
    i_valid = 1'b1; i_address = 32'h100; i_lookahead = 32'h104;
    d_wstrobe = 4'hF; d_wdata = 32'h5555_AAAA;
    m_ready = 1'b1; m_rdata = 32'hCAFE_0001;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_address !== 32'h100 || i_ready !== 1'b1 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL ibus_single: got valid=%b addr=%h i_rdy=%b d_rdy=%b expected 1 00000100 1 0",
               m_valid, m_address, i_ready, d_ready);
    end
    checks++;
    if (m_wstrobe !== 4'h0 || m_wdata !== 32'h0 || m_lookahead !== 32'h104 || i_rdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL ibus_fields: got strb=%h wdata=%h la=%h rdata=%h expected 0 00000000 00000104 cafe0001",
               m_wstrobe, m_wdata, m_lookahead, i_rdata);
    end
    step();
    i_valid = 1'b0; d_valid = 1'b1; d_address = 32'h180; d_wstrobe = 4'h0;
    #1;
    checks++;
    if (d_ready !== 1'b1 || m_address !== 32'h180) begin
      errors++; $display("FAIL stayed_idle: got d_rdy=%b addr=%h expected 1 00000180", d_ready, m_address);
    end
    d_valid = 1'b0;
  endtask

  task automatic test_both_fixed();
    step();
    i_valid = 1'b1; i_address = 32'h110;
    d_valid = 1'b1; d_address = 32'h200; d_wstrobe = 4'hF; d_wdata = 32'hDEAD_BEEF;
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
      errors++; $display("FAIL both_d_first: got d_rdy=%b i_rdy=%b expected 1 0", d_ready, i_ready);
    end
    checks++;
    if (m_address !== 32'h200 || m_wstrobe !== 4'hF || m_wdata !== 32'hDEAD_BEEF || m_lookahead !== 32'h200) begin
      errors++;
      $display("FAIL dbus_fields: got addr=%h strb=%h wdata=%h la=%h expected 00000200 f deadbeef 00000200",
               m_address, m_wstrobe, m_wdata, m_lookahead);
    end
    checks++;
    if (d_rdata !== 32'h1234_5678) begin errors++; $display("FAIL d_rdata: got %h expected 12345678", d_rdata); end
    step();
    d_valid = 1'b0;
    #1;
    checks++;
    if (i_ready !== 1'b1 || d_ready !== 1'b0 || m_address !== 32'h110 || m_wstrobe !== 4'h0 || m_wdata !== 32'h0) begin
      errors++;
      $display("FAIL both_i_next: got i_rdy=%b d_rdy=%b addr=%h strb=%h wdata=%h expected 1 0 00000110 0 00000000",
               i_ready, d_ready, m_address, m_wstrobe, m_wdata);
    end
    step();
    i_valid = 1'b0;
  endtask

  task automatic test_lock_d();
    step();
    d_valid = 1'b1; d_address = 32'h300; d_wstrobe = 4'h0; m_ready = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_address !== 32'h300 || d_ready !== 1'b0) begin
      errors++; $display("FAIL lock_issue: got valid=%b addr=%h d_rdy=%b expected 1 00000300 0", m_valid, m_address, d_ready);
    end
    step();
    i_valid = 1'b1; i_address = 32'h400;
    #1;
    checks++;
    if (m_address !== 32'h300 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL lock_hold2: got addr=%h i_rdy=%b d_rdy=%b expected 00000300 0 0", m_address, i_ready, d_ready);
    end
    step();
    #1;
    checks++;
    if (m_address !== 32'h300 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL lock_hold3: got addr=%h i_rdy=%b d_rdy=%b expected 00000300 0 0", m_address, i_ready, d_ready);
    end
    step();
    m_ready = 1'b1;
    #1;
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || m_address !== 32'h300) begin
      errors++; $display("FAIL lock_done: got d_rdy=%b i_rdy=%b addr=%h expected 1 0 00000300", d_ready, i_ready, m_address);
    end
    step();
    d_valid = 1'b0;
    #1;
    checks++;
    if (i_ready !== 1'b1 || m_address !== 32'h400) begin
      errors++; $display("FAIL lock_i_after: got i_rdy=%b addr=%h expected 1 00000400", i_ready, m_address);
    end
    step();
    i_valid = 1'b0;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    byte exp_pat [8];
    byte got;
    exp_pat = '{"I", "D", "I", "D", "I", "D", "I", "D"};
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_valid = 1'b1; d_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      got = d_ready ? "D" : (i_ready ? "I" : "-");
      checks++;
      if (got !== exp_pat[c]) begin
        errors++; $display("FAIL rr_grant[%0d]: got %c expected %c", c, got, exp_pat[c]);
      end
      step();
    end
    i_valid = 1'b0; d_valid = 1'b0;
  endtask
`else
  task automatic test_d_starvation();
    byte exp_pat [10];
    byte got;
    exp_pat = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
    step();
    i_valid = 1'b1; d_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      got = d_ready ? "D" : (i_ready ? "I" : "-");
      checks++;
      if (got !== exp_pat[c]) begin
        errors++; $display("FAIL run_grant[%0d]: got %c expected %c", c, got, exp_pat[c]);
      end
      step();
    end
    i_valid = 1'b0; d_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_lock();
    step();
    i_valid = 1'b1; i_address = 32'h500; d_valid = 1'b0; m_ready = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_address !== 32'h500) begin
      errors++; $display("FAIL lock_i_issue: got valid=%b addr=%h expected 1 00000500", m_valid, m_address);
    end
    step();
    d_valid = 1'b1; d_address = 32'h600; m_ready = 1'b0;
    #1;
    checks++;
    if (m_address !== 32'h500 || d_ready !== 1'b0) begin
      errors++; $display("FAIL lock_i_hold: got addr=%h d_rdy=%b expected 00000500 0", m_address, d_ready);
    end
    d_valid = 1'b0; m_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_lock: got valid=%b i_rdy=%b d_rdy=%b expected 0 0 0", m_valid, i_ready, d_ready);
    end
    step();
    reset = 1'b0;
    i_valid = 1'b0; d_valid = 1'b1; d_address = 32'h700; m_ready = 1'b1;
    #1;
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || m_address !== 32'h700) begin
      errors++; $display("FAIL no_stale_lock: got d_rdy=%b i_rdy=%b addr=%h expected 1 0 00000700", d_ready, i_ready, m_address);
    end
    step();
    d_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_address = 32'h0; i_lookahead = 32'h0;
    d_valid = 1'b0; d_address = 32'h0; d_wstrobe = 4'h0; d_wdata = 32'h0;
    m_ready = 1'b0; m_rdata = 32'h0; m_irq = 1'b0;

    test_reset();
    test_single_ibus();
    test_both_fixed();
    test_lock_d();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_d_starvation();
`endif
    test_reset_mid_lock();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
